// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan reader and the segment encoder drivers.
// Glyph table is active-high gfedcba; both ends index it by hex value.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] GLYPH_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } reader_state_t;

    // Caller guarantees a one-hot input; the highest set bit wins otherwise.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-bit segment pattern to hex nibble lookup, no latency, no backpressure.
// o_hit is low when the pattern matches no glyph; o_nibble is then 0.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_hit    = 1'b0;
        o_nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == GLYPH_TABLE[i]) begin
                o_hit    = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Rebuilds the 4-digit hex word from a scanned 7-segment bus; capture visible STABLE_CYCLES+1 edges after a pattern arrives.
// Passive observer: no backpressure, inputs are sampled every cycle.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES   = 65536,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  digit_in,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic [15:0] frame_value,
    output logic        pattern_err,
    output logic        stale
);

    localparam int DW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DW-1:0] STABLE_LIM  = DW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES);

    logic [7:0]    r_seg_q;
    logic [3:0]    r_dig_q;
    logic [11:0]   r_prev_sample;
    reader_state_t r_state;
    logic [DW-1:0] r_dwell;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_mask;
    logic [15:0]   r_value;
    logic [3:0]    r_dp;
    logic [3:0]    r_digit_valid;
    logic          r_frame_valid;
    logic [15:0]   r_frame_value;
    logic          r_pattern_err;
    logic          r_stale;

    logic [7:0]    w_seg_n;
    logic [3:0]    w_dig_n;
    logic [11:0]   w_sample;
    logic          w_selectable;
    logic          w_same;
    reader_state_t w_state_nxt;
    logic [DW-1:0] w_dwell_nxt;
    logic          w_capture;
    logic [1:0]    w_cap_idx;
    logic          w_hit;
    logic [3:0]    w_nibble;
    logic [15:0]   w_value_upd;
    logic [3:0]    w_mask_upd;

    // Internally 1 = lit / enabled regardless of board polarity.
    assign w_seg_n      = r_seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign w_dig_n      = r_dig_q ^ {4{DIGIT_ACTIVE_LOW}};
    assign w_sample     = {w_dig_n, w_seg_n};
    assign w_selectable = $onehot(w_dig_n);
    assign w_same       = (w_sample == r_prev_sample);
    assign w_cap_idx    = onehot_to_idx(w_dig_n);

    seg7_glyph_decode u_decode (
        .i_pattern (w_seg_n[SEG_G:SEG_A]),
        .o_hit     (w_hit),
        .o_nibble  (w_nibble)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_capture   = 1'b0;
        if (!w_selectable) begin
            w_state_nxt = IDLE;
            w_dwell_nxt = '0;
        end else if (!(r_state == HELD && w_same)) begin
            // Any change restarts the dwell on the new sample.
            w_dwell_nxt = (r_state == DWELL && w_same) ? r_dwell + DW'(1) : DW'(1);
            if (w_dwell_nxt == STABLE_LIM) begin
                w_capture   = 1'b1;
                w_state_nxt = HELD;
            end else begin
                w_state_nxt = DWELL;
            end
        end
    end

    always_comb begin
        w_value_upd = r_value;
        w_value_upd[{w_cap_idx, 2'b00} +: 4] = w_nibble;
        w_mask_upd  = r_mask | (4'b0001 << w_cap_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q       <= '0;
            r_dig_q       <= '0;
            r_prev_sample <= '0;
            r_state       <= IDLE;
            r_dwell       <= '0;
            r_to_cnt      <= '0;
            r_mask        <= '0;
            r_value       <= '0;
            r_dp          <= '0;
            r_digit_valid <= '0;
            r_frame_valid <= 1'b0;
            r_frame_value <= '0;
            r_pattern_err <= 1'b0;
            r_stale       <= 1'b0;
        end else begin
            r_seg_q       <= seg_in;
            r_dig_q       <= digit_in;
            r_prev_sample <= w_sample;
            r_state       <= w_state_nxt;
            r_dwell       <= w_dwell_nxt;
            r_frame_valid <= 1'b0;
            r_pattern_err <= 1'b0;
            if (w_capture) begin
                r_to_cnt <= '0;
                r_stale  <= 1'b0;
                if (w_hit) begin
                    r_value                  <= w_value_upd;
                    r_dp[w_cap_idx]          <= w_seg_n[SEG_DP];
                    r_digit_valid[w_cap_idx] <= 1'b1;
                    if (w_mask_upd == 4'hF) begin
                        r_frame_valid <= 1'b1;
                        r_frame_value <= w_value_upd;
                        r_mask        <= '0;
                    end else begin
                        r_mask <= w_mask_upd;
                    end
                end else begin
                    r_digit_valid[w_cap_idx] <= 1'b0;
                    r_pattern_err            <= 1'b1;
                end
            end else if (r_to_cnt != TIMEOUT_LIM) begin
                // Saturates at the limit; stale side effects fire once on arrival.
                r_to_cnt <= r_to_cnt + TW'(1);
                if (r_to_cnt + TW'(1) == TIMEOUT_LIM) begin
                    r_stale       <= 1'b1;
                    r_digit_valid <= '0;
                    r_mask        <= '0;
                end
            end
        end
    end

    assign value       = r_value;
    assign dp_out      = r_dp;
    assign digit_valid = r_digit_valid;
    assign frame_valid = r_frame_valid;
    assign frame_value = r_frame_value;
    assign pattern_err = r_pattern_err;
    assign stale       = r_stale;

endmodule
